// File: rtl/nibble_packer13.sv
// nibble_packer13: collects N slot words of W bits into one packed word.
// Slot k of the packed word occupies out_data[W*k +: W]. Once all N slots
// are written the word is held until the consumer takes it; flush discards
// the current word in either state.
module nibble_packer13 #(
    parameter int N = 13,
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N*W-1:0]   out_data,
    output logic [3:0]       fill_count
);

    localparam int CW = 4;
    localparam logic [CW-1:0] COUNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] COUNT_MAX  = CW'(N);

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } state_t;

    state_t           state_q,      state_d;
    logic [CW-1:0]    fill_count_q, fill_count_d;
    logic [N*W-1:0]   data_q,       data_d;

    // State, slot counter and packed word registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FILL;
            fill_count_q <= {CW{1'b0}};
            data_q       <= {(N*W){1'b0}};
        end else begin
            state_q      <= state_d;
            fill_count_q <= fill_count_d;
            data_q       <= data_d;
        end
    end

    // Next-state logic: flush first, then acceptance in FILL or handoff in FULL.
    always_comb begin
        state_d      = state_q;
        fill_count_d = fill_count_q;
        data_d       = data_q;
        if (flush) begin
            state_d      = S_FILL;
            fill_count_d = {CW{1'b0}};
            data_d       = {(N*W){1'b0}};
        end else begin
            case (state_q)
                S_FILL: begin
                    // The count guard keeps fill_count from ever passing N.
                    if (in_valid && (fill_count_q < COUNT_MAX)) begin
                        for (int k = 0; k < N; k++) begin
                            if (fill_count_q == CW'(k)) begin
                                data_d[k*W +: W] = in_data;
                            end else begin
                                data_d[k*W +: W] = data_q[k*W +: W];
                            end
                        end
                        fill_count_d = fill_count_q + 4'd1;
                        if (fill_count_q == COUNT_LAST) begin
                            state_d = S_FULL;
                        end else begin
                            state_d = S_FILL;
                        end
                    end else begin
                        state_d      = S_FILL;
                        fill_count_d = fill_count_q;
                    end
                end
                S_FULL: begin
                    // Input is ignored here; the producer holds until in_ready.
                    if (out_ready) begin
                        state_d      = S_FILL;
                        fill_count_d = {CW{1'b0}};
                        data_d       = {(N*W){1'b0}};
                    end else begin
                        state_d      = S_FULL;
                        fill_count_d = fill_count_q;
                        data_d       = data_q;
                    end
                end
                default: begin
                    state_d      = S_FILL;
                    fill_count_d = {CW{1'b0}};
                    data_d       = {(N*W){1'b0}};
                end
            endcase
        end
    end

    // Handshake outputs decode the state register only, so no input reaches them.
    assign in_ready   = (state_q == S_FILL);
    assign out_valid  = (state_q == S_FULL);
    assign out_data   = data_q;
    assign fill_count = fill_count_q;

endmodule

// File: tb/tb_nibble_packer13.sv
// Self-checking bench for nibble_packer13: expected packed words are pushed
// to a scoreboard queue as slots are driven and popped when out_valid rises.
module tb_nibble_packer13;

    localparam int N = 13;
    localparam int W = 4;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic           flush;
    logic           out_valid;
    logic           out_ready;
    logic [N*W-1:0] out_data;
    logic [3:0]     fill_count;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [N*W-1:0] exp_q[$];
    logic [N*W-1:0] exp_word;
    logic [N*W-1:0] held_word;

    nibble_packer13 #(.N(N), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .fill_count (fill_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Fill one full word with the given slot values and push it to the scoreboard.
    task automatic fill_word(input logic [W-1:0] vals [N]);
        logic [N*W-1:0] w;
        w = '0;
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1;
            in_data  = vals[i];
            w[i*W +: W] = vals[i];
            step();
        end
        in_valid = 1'b0;
        exp_q.push_back(w);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = 4'h0; flush = 1'b0; out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass_cnt++;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass_cnt++;
        total_cnt++;
        if (out_data !== 52'h0) $display("FAIL reset_out_data got %h want 0", out_data); else pass_cnt++;
        total_cnt++;
        if (fill_count !== 4'd0) $display("FAIL reset_fill_count got %0d want 0", fill_count); else pass_cnt++;
    endtask

    task automatic test_fill();
        logic [W-1:0] vals [N];
        for (int i = 0; i < N; i++) vals[i] = 4'(i);
        // First slot is visible one cycle after acceptance in slot 0.
        in_valid = 1'b1; in_data = vals[0];
        step();
        total_cnt++;
        if (out_data !== 52'h0 || fill_count !== 4'd1)
            $display("FAIL fill_first_slot got %h/%0d want 0/1", out_data, fill_count);
        else pass_cnt++;
        for (int i = 1; i < N; i++) begin
            in_data = vals[i];
            step();
        end
        in_valid = 1'b0;
        exp_q.push_back(52'hCBA9876543210);
        total_cnt++;
        if (out_valid !== 1'b1) $display("FAIL fill_out_valid got %b want 1", out_valid); else pass_cnt++;
        total_cnt++;
        if (exp_q.size() == 0) $display("FAIL fill_sb_empty got 0 want 1 entries");
        else begin
            exp_word = exp_q.pop_front();
            if (out_data !== exp_word) $display("FAIL fill_out_data got %h want %h", out_data, exp_word);
            else pass_cnt++;
        end
        total_cnt++;
        if (fill_count !== 4'd13) $display("FAIL fill_count_full got %0d want 13", fill_count); else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL fill_in_ready got %b want 0", in_ready); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        held_word = 52'hCBA9876543210;
        in_valid = 1'b1; in_data = 4'hF; out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            total_cnt++;
            if (out_data !== held_word || out_valid !== 1'b1 || fill_count !== 4'd13)
                $display("FAIL bp_hold c%0d got %h/%b/%0d want %h/1/13", c, out_data, out_valid, fill_count, held_word);
            else pass_cnt++;
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0; in_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0 || out_data !== 52'h0 || fill_count !== 4'd0 || in_ready !== 1'b1)
            $display("FAIL bp_release got v%b d%h c%0d r%b want v0 d0 c0 r1", out_valid, out_data, fill_count, in_ready);
        else pass_cnt++;
    endtask

    task automatic test_gapped();
        in_valid = 1'b1; in_data = 4'h5; out_ready = 1'b1;   // out_ready in FILL has no effect
        step();
        in_valid = 1'b0;
        step(); step(); step();
        in_valid = 1'b1; in_data = 4'hA;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        total_cnt++;
        if (out_data !== 52'hA5) $display("FAIL gap_out_data got %h want a5", out_data); else pass_cnt++;
        total_cnt++;
        if (fill_count !== 4'd2) $display("FAIL gap_fill_count got %0d want 2", fill_count); else pass_cnt++;
        flush = 1'b1;
        step();
        flush = 1'b0;
        total_cnt++;
        if (fill_count !== 4'd0 || out_data !== 52'h0)
            $display("FAIL gap_flush got %0d/%h want 0/0", fill_count, out_data);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_data = 4'hF;
            step();
        end
        total_cnt++;
        if (out_data !== 52'hFFFFFFF || fill_count !== 4'd7)
            $display("FAIL flush_prefill got %h/%0d want fffffff/7", out_data, fill_count);
        else pass_cnt++;
        flush = 1'b1; in_valid = 1'b1; in_data = 4'h3;
        step();
        flush = 1'b0;
        total_cnt++;
        if (fill_count !== 4'd0 || out_data !== 52'h0)
            $display("FAIL flush_clear got %0d/%h want 0/0", fill_count, out_data);
        else pass_cnt++;
        step();
        in_valid = 1'b0;
        total_cnt++;
        if (out_data !== 52'h3 || fill_count !== 4'd1)
            $display("FAIL flush_slot0 got %h/%0d want 3/1", out_data, fill_count);
        else pass_cnt++;
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] vals [N];
        for (int i = 0; i < N; i++) vals[i] = 4'($urandom_range(0, 15));
        out_ready = 1'b0;
        fill_word(vals);
        total_cnt++;
        if (out_valid !== 1'b1) $display("FAIL rstmid_full got %b want 1", out_valid); else pass_cnt++;
        // The held word is discarded by reset; drop it from the scoreboard too.
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        rst = 1'b1; flush = 1'b1;
        step();
        rst = 1'b0; flush = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0 || out_data !== 52'h0 || fill_count !== 4'd0 || in_ready !== 1'b1)
            $display("FAIL rstmid_clear got v%b d%h c%0d r%b want v0 d0 c0 r1", out_valid, out_data, fill_count, in_ready);
        else pass_cnt++;
        for (int i = 0; i < N; i++) vals[i] = 4'($urandom_range(0, 15));
        fill_word(vals);
        total_cnt++;
        if (exp_q.size() == 0 || out_valid !== 1'b1) $display("FAIL rstmid_refill got v%b want 1", out_valid);
        else begin
            exp_word = exp_q.pop_front();
            if (out_data !== exp_word) $display("FAIL rstmid_refill got %h want %h", out_data, exp_word);
            else pass_cnt++;
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] src [2*N];
        logic [N*W-1:0] w;
        int idx, nslot, words_seen, valid_run, valid_run_max, low_run, low_run_max, low_total, cyc;
        logic rdy_now;
        for (int i = 0; i < 2*N; i++) src[i] = 4'($urandom_range(0, 15));
        idx = 0; nslot = 0; w = '0; words_seen = 0; valid_run = 0; valid_run_max = 0;
        low_run = 0; low_run_max = 0; low_total = 0; cyc = 0;
        out_ready = 1'b1;
        while (cyc < 200 && !(words_seen == 2 && in_ready === 1'b1)) begin
            if (idx < 2*N) begin in_valid = 1'b1; in_data = src[idx]; end
            else in_valid = 1'b0;
            rdy_now = in_ready;
            step();
            cyc++;
            if (in_valid && rdy_now) begin
                w[nslot*W +: W] = src[idx];
                idx++; nslot++;
                if (nslot == N) begin exp_q.push_back(w); w = '0; nslot = 0; end
            end
            if (out_valid === 1'b1) begin
                valid_run++;
                if (valid_run == 1) begin
                    words_seen++;
                    total_cnt++;
                    if (exp_q.size() == 0) $display("FAIL b2b_sb_empty word %0d", words_seen);
                    else begin
                        exp_word = exp_q.pop_front();
                        if (out_data !== exp_word) $display("FAIL b2b_word%0d got %h want %h", words_seen, out_data, exp_word);
                        else pass_cnt++;
                    end
                end
            end else valid_run = 0;
            if (valid_run > valid_run_max) valid_run_max = valid_run;
            if (in_ready === 1'b0) begin low_run++; low_total++; end else low_run = 0;
            if (low_run > low_run_max) low_run_max = low_run;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        total_cnt++;
        if (words_seen != 2) $display("FAIL b2b_words got %0d want 2 (cycles %0d)", words_seen, cyc); else pass_cnt++;
        total_cnt++;
        if (valid_run_max != 1) $display("FAIL b2b_valid_run got %0d want 1", valid_run_max); else pass_cnt++;
        total_cnt++;
        if (low_run_max != 1 || low_total != 2)
            $display("FAIL b2b_ready_low got run%0d total%0d want run1 total2", low_run_max, low_total);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_backpressure();
        test_gapped();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/nibble_packer13.md
NIBBLE_PACKER13 -- requirements
Module: nibble_packer13

Interface
REQ-001 SHALL have parameter N, default 13, number of slots in the packed word.
REQ-002 SHALL have parameter W, default 4, width of each slot in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  producer presents a slot word.
REQ-006 SHALL have port in_ready  output  1  packer accepts a slot word this cycle.
REQ-007 SHALL have port in_data  input  W  slot word.
REQ-008 SHALL have port flush  input  1  discard the partial or complete word.
REQ-009 SHALL have port out_valid  output  1  packed word is complete and held.
REQ-010 SHALL have port out_ready  input  1  consumer takes the packed word.
REQ-011 SHALL have port out_data  output  N*W  packed word; slot k occupies bits [W*k+W-1 : W*k].
REQ-012 SHALL have port fill_count  output  4  number of slots written in the current word, 0..N.

Function
REQ-013 SHALL implement two states: FILL (collecting) and FULL (holding the complete word).
REQ-014 In FILL: in_ready=1 and out_valid=0; in FULL: in_ready=0 and out_valid=1.
REQ-015 SHALL accept an input on any cycle with in_valid and in_ready both high; at that edge, write in_data into slot fill_count and increment fill_count by 1.
REQ-016 SHALL move from FILL to FULL on the edge that accepts slot N-1, with fill_count=N; out_valid rises the next cycle, so latency from the last accept to out_valid is 1 cycle.
REQ-017 SHALL hold out_data and fill_count stable while in FULL and out_ready=0.
REQ-018 On an edge in FULL with out_ready=1: clear out_data to 0, set fill_count=0, return to FILL; in_ready is high the following cycle, with no same-cycle bypass.
REQ-019 SHALL ignore in_valid in FULL and drop no accepted data; the producer holds in_data until in_ready.
REQ-020 SHALL hold out_data slots at or above fill_count at 0 during FILL; written slots are visible on out_data one cycle after acceptance.
REQ-021 flush=1 at an edge SHALL clear out_data to 0, set fill_count=0 and enter FILL, in either state, taking priority over acceptance and the output handshake.
REQ-022 out_ready in FILL SHALL have no effect.
REQ-023 fill_count SHALL never exceed N and SHALL never wrap; the slot index SHALL be zero-extended for W*k addressing.
REQ-024 All outputs SHALL be registered or decoded from state only, with no combinational path from inputs to outputs.

Reset
REQ-025 With rst=1 at an edge: state=FILL, fill_count=0, out_data=0, out_valid=0, in_ready=1.
REQ-026 rst SHALL take priority over flush and all handshakes, and an in-progress or held word SHALL be discarded.
REQ-027 The first accepting edge after rst deasserts SHALL write slot 0.

Verification
REQ-028 Fill sequence: after reset, in_valid=1 for 13 cycles with in_data=0x0..0xC -> out_valid=1 on the next cycle, out_data=0xCBA9876543210, fill_count=13, in_ready=0.
REQ-029 Backpressure: in the REQ-028 full state, hold out_ready=0 for 5 cycles while in_valid=1, in_data=0xF -> out_data unchanged; then out_ready=1 for 1 cycle -> next cycle out_valid=0, out_data=0, fill_count=0, in_ready=1.
REQ-030 Gapped input: write 0x5, idle 3 cycles, write 0xA -> out_data=0x...A5 (bits [7:0]=0xA5, rest 0), fill_count=2.
REQ-031 Flush mid-fill: write 7 slots of 0xF, assert flush together with in_valid and in_data=0x3 -> next cycle fill_count=0, out_data=0; the following accept of 0x3 lands in slot 0.
REQ-032 Reset mid-operation: in FULL with out_ready=0, assert rst for 1 cycle -> out_valid=0, out_data=0, fill_count=0; a new 13-slot fill completes normally.
REQ-033 Back-to-back words: two 13-slot fills with out_ready tied high -> each word is presented for exactly 1 cycle with correct contents, and in_ready is low for exactly 1 cycle between words.
